// File: rtl/vector_sub_seq_pkg.sv
// Shared types for the sequential vector subtractor.
//   fixed_point : 32-bit signed Q16.16 scalar type and its saturation limits.
//   vector      : packed three-axis vector of fixed_point_t and an axis selector.
// No ports; imported by fixed_point_sub and vector_sub_seq.

package fixed_point;
  localparam int FP_WIDTH = 32;
  localparam int FP_FRAC  = 16;

  typedef logic signed [FP_WIDTH-1:0] fixed_point_t;

  localparam fixed_point_t FP_MAX = 32'sh7FFF_FFFF;
  localparam fixed_point_t FP_MIN = 32'sh8000_0000;
endpackage

package vector;
  import fixed_point::*;

  // x occupies the most significant 32 bits, z the least significant.
  typedef struct packed {
    fixed_point_t x;
    fixed_point_t y;
    fixed_point_t z;
  } vector_t;

  typedef enum logic [1:0] {
    AXIS_X = 2'd0,
    AXIS_Y = 2'd1,
    AXIS_Z = 2'd2
  } axis_e;
endpackage

// File: rtl/vector_sub_seq_fixed_point_sub.sv
// fixed_point_sub: combinational Q16.16 subtractor, result = op1 - op2.
// Ports:
//   op1      in  fixed_point_t  minuend
//   op2      in  fixed_point_t  subtrahend
//   result   out fixed_point_t  two's-complement wrapped difference
//   overflow out 1              signed overflow of the subtraction
// Saturation is left to the caller so this block stays a pure datapath.

module fixed_point_sub
  import fixed_point::*;
(
  input  fixed_point_t op1,
  input  fixed_point_t op2,
  output fixed_point_t result,
  output logic         overflow
);

  localparam int MSB = FP_WIDTH - 1;

  assign result = op1 - op2;

  // Subtraction can only overflow when the operand signs differ, and it has
  // overflowed exactly when the wrapped result lost the minuend's sign.
  assign overflow = (op1[MSB] != op2[MSB]) && (result[MSB] != op1[MSB]);

endmodule

// File: rtl/vector_sub_seq.sv
// vector_sub_seq: three-axis Q16.16 vector subtractor (result = op1 - op2)
// that reuses one fixed_point_sub across x, y, z, one axis per cycle.
// Ports:
//   clk           in  1         clock, all state on rising edge
//   rst_n         in  1         synchronous active-low reset
//   in_valid      in  1         operand pair presented
//   in_ready      out 1         block can accept operands (IDLE only)
//   op1, op2      in  vector_t  minuend / subtrahend
//   out_valid     out 1         result held and valid (DONE only)
//   out_ready     in  1         consumer accepts result
//   result        out vector_t  per-axis difference
//   overflow      out 1         OR of overflow_axis
//   overflow_axis out 3         per-axis overflow, bit0=x bit1=y bit2=z
// Parameter SATURATE: 0 wraps on overflow, 1 clamps to FP_MAX/FP_MIN.

module vector_sub_seq
  import fixed_point::*;
  import vector::*;
#(
  parameter int SATURATE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  vector_t      op1,
  input  vector_t      op2,
  output logic         out_valid,
  input  logic         out_ready,
  output vector_t      result,
  output logic         overflow,
  output logic [2:0]   overflow_axis
);

  localparam int MSB = FP_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SUB_X = 3'd1,
    SUB_Y = 3'd2,
    SUB_Z = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e       state_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;
  vector_t      op1_reg;
  vector_t      op2_reg;
  fixed_point_t res_reg [3];
  logic         ovf_reg [3];

  axis_e        cur_axis;
  logic         sub_active;
  fixed_point_t mux_a;
  fixed_point_t mux_b;
  fixed_point_t diff;
  logic         diff_ovf;
  fixed_point_t axis_value;
  logic         accept;

  // Axis currently being computed, derived from the FSM state.
  always_comb begin
    cur_axis   = AXIS_X;
    sub_active = 1'b0;
    case (state_reg)
      SUB_X: begin cur_axis = AXIS_X; sub_active = 1'b1; end
      SUB_Y: begin cur_axis = AXIS_Y; sub_active = 1'b1; end
      SUB_Z: begin cur_axis = AXIS_Z; sub_active = 1'b1; end
      default: begin cur_axis = AXIS_X; sub_active = 1'b0; end
    endcase
  end

  // Operand mux feeding the single shared subtractor from the captured vectors.
  always_comb begin
    mux_a = op1_reg.x;
    mux_b = op2_reg.x;
    case (cur_axis)
      AXIS_Y: begin mux_a = op1_reg.y; mux_b = op2_reg.y; end
      AXIS_Z: begin mux_a = op1_reg.z; mux_b = op2_reg.z; end
      default: begin mux_a = op1_reg.x; mux_b = op2_reg.x; end
    endcase
  end

  fixed_point_sub u_sub (
    .op1      (mux_a),
    .op2      (mux_b),
    .result   (diff),
    .overflow (diff_ovf)
  );

  // On overflow the true result lies beyond the range on the minuend's side,
  // so the clamp direction follows the minuend's sign.
  always_comb begin
    axis_value = diff;
    if ((SATURATE != 0) && diff_ovf) begin
      axis_value = mux_a[MSB] ? FP_MIN : FP_MAX;
    end
  end

  assign accept = (state_reg == IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      op1_reg       <= '0;
      op2_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op1_reg      <= op1;
            op2_reg      <= op2;
            in_ready_reg <= 1'b0;
            state_reg    <= SUB_X;
          end
        end
        SUB_X: state_reg <= SUB_Y;
        SUB_Y: state_reg <= SUB_Z;
        SUB_Z: begin
          state_reg     <= DONE;
          out_valid_reg <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  // One result/flag register per axis, written only in that axis's cycle, so
  // the other axes keep their previous values while the vector is in flight.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          res_reg[gi] <= '0;
          ovf_reg[gi] <= 1'b0;
        end else if (accept) begin
          ovf_reg[gi] <= 1'b0;
        end else if (sub_active && (cur_axis == axis_e'(gi))) begin
          res_reg[gi] <= axis_value;
          ovf_reg[gi] <= diff_ovf;
        end
      end
    end
  endgenerate

  assign result.x      = res_reg[0];
  assign result.y      = res_reg[1];
  assign result.z      = res_reg[2];
  assign overflow_axis = {ovf_reg[2], ovf_reg[1], ovf_reg[0]};
  assign overflow      = |overflow_axis;

  // Handshake outputs are forced low for as long as reset is asserted.
  assign in_ready  = in_ready_reg & rst_n;
  assign out_valid = out_valid_reg & rst_n;

endmodule

// File: tb/tb_vector_sub_seq.sv
// Self-checking bench for vector_sub_seq. Two instances (wrap and saturate)
// share the same stimulus and are checked against an integer-arithmetic model.

module tb_vector_sub_seq;
  import fixed_point::*;
  import vector::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  vector_t    op1 = '0;
  vector_t    op2 = '0;

  logic       ir_w, ov_w, of_w, ir_s, ov_s, of_s;
  vector_t    res_w, res_s;
  logic [2:0] ax_w, ax_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  vector_sub_seq #(.SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w),
    .op1(op1), .op2(op2), .out_valid(ov_w), .out_ready(out_ready),
    .result(res_w), .overflow(of_w), .overflow_axis(ax_w)
  );

  vector_sub_seq #(.SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s),
    .op1(op1), .op2(op2), .out_valid(ov_s), .out_ready(out_ready),
    .result(res_s), .overflow(of_s), .overflow_axis(ax_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // in_ready and out_valid must never be high together.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if ((ir_w && ov_w) || (ir_s && ov_s)) begin
        bad++;
        $display("FAIL handshake_exclusive: in_ready=%b/%b out_valid=%b/%b required not both 1",
                 ir_w, ir_s, ov_w, ov_s);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic vector_t mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    vector_t v;
    v.x = x; v.y = y; v.z = z;
    return v;
  endfunction

  // Reference: exact integer difference, then range check and wrap/clamp.
  function automatic void model(input vector_t a, input vector_t b, input bit sat,
                                output vector_t r, output logic [2:0] ov);
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [31:0] rv [3];
    av[0] = a.x; av[1] = a.y; av[2] = a.z;
    bv[0] = b.x; bv[1] = b.y; bv[2] = b.z;
    for (int i = 0; i < 3; i++) begin
      longint d;
      d = longint'($signed(av[i])) - longint'($signed(bv[i]));
      ov[i] = (d > 64'sd2147483647) || (d < -64'sd2147483648);
      if (sat && ov[i]) rv[i] = (d > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else              rv[i] = d[31:0];
    end
    r = mk(rv[0], rv[1], rv[2]);
  endfunction

  function automatic logic [31:0] rnd_fp();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic vector_t rnd_vec();
    return mk(rnd_fp(), rnd_fp(), rnd_fp());
  endfunction

  // Call at a negedge with the DUTs in IDLE; returns at the negedge after accept.
  task automatic send(input string tag, input vector_t a, input vector_t b, input bit hold);
    chk({tag, " in_ready_wrap"}, 96'(ir_w), 96'd1);
    chk({tag, " in_ready_sat"},  96'(ir_s), 96'd1);
    op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    op1 = rnd_vec();
    op2 = rnd_vec();
  endtask

  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (!(ov_w && ov_s) && cycles < 20) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 20) begin
      total++; bad++;
      $display("FAIL %s timeout: out_valid=%b/%b required 1 within 20 cycles", tag, ov_w, ov_s);
    end
  endtask

  task automatic check_out(input string tag, input vector_t rw, input logic [2:0] ow,
                           input vector_t rs, input logic [2:0] os);
    chk({tag, " result_wrap"}, res_w, rw);
    chk({tag, " axis_wrap"},   96'(ax_w), 96'(ow));
    chk({tag, " ovf_wrap"},    96'(of_w), 96'(|ow));
    chk({tag, " result_sat"},  res_s, rs);
    chk({tag, " axis_sat"},    96'(ax_s), 96'(os));
    chk({tag, " ovf_sat"},     96'(of_s), 96'(|os));
  endtask

  // Full transaction with out_ready=1: accept, 3-cycle latency, result, back to IDLE.
  task automatic run_one(input string tag, input vector_t a, input vector_t b,
                         input vector_t rw, input logic [2:0] ow,
                         input vector_t rs, input logic [2:0] os);
    int c;
    out_ready = 1'b1;
    send(tag, a, b, 1'b0);
    wait_valid(tag, c);
    chk({tag, " latency"}, 96'(c), 96'd3);
    check_out(tag, rw, ow, rs, os);
    chk({tag, " in_ready_in_done"}, 96'({ir_w, ir_s}), 96'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle_after"}, 96'({ov_w, ov_s, ir_w, ir_s}), 96'b0011);
    $display("txn %s op1=%h op2=%h wrap=%h/%b sat=%h/%b", tag, a, b, res_w, ax_w, res_s, ax_s);
  endtask

  typedef struct {
    string      name;
    vector_t    a;
    vector_t    b;
    vector_t    rw;
    logic [2:0] ow;
    vector_t    rs;
    logic [2:0] os;
  } vec_rec_t;

  vec_rec_t tbl[$];

  task automatic add(input string n, input vector_t a, input vector_t b, input vector_t rw,
                     input logic [2:0] ow, input vector_t rs, input logic [2:0] os);
    vec_rec_t r;
    r.name = n; r.a = a; r.b = b; r.rw = rw; r.ow = ow; r.rs = rs; r.os = os;
    tbl.push_back(r);
  endtask

  initial begin
    vector_t a, b, c2, rw, rs;
    logic [2:0] ow, os;
    int cnt, t_prev;

    add("basic", mk(32'h0003_0000, 32'h0001_8000, 32'hFFFE_0000),
                 mk(32'h0001_0000, 32'h0002_0000, 32'hFFFE_0000),
                 mk(32'h0002_0000, 32'hFFFF_8000, 32'h0), 3'b000,
                 mk(32'h0002_0000, 32'hFFFF_8000, 32'h0), 3'b000);
    add("ovf_x", mk(32'h7FFF_0000, 32'h0, 32'h0), mk(32'hFFFF_0000, 32'h0, 32'h0),
                 mk(32'h8000_0000, 32'h0, 32'h0), 3'b001,
                 mk(32'h7FFF_FFFF, 32'h0, 32'h0), 3'b001);
    add("ovf_z", mk(32'h0, 32'h0, 32'h8000_0000), mk(32'h0, 32'h0, 32'h0001_0000),
                 mk(32'h0, 32'h0, 32'h7FFF_0000), 3'b100,
                 mk(32'h0, 32'h0, 32'h8000_0000), 3'b100);
    add("identical", mk(32'h1234_5678, 32'h8000_0000, 32'h7FFF_FFFF),
                     mk(32'h1234_5678, 32'h8000_0000, 32'h7FFF_FFFF),
                     mk(32'h0, 32'h0, 32'h0), 3'b000, mk(32'h0, 32'h0, 32'h0), 3'b000);
    add("minus_min", mk(32'h0, 32'h1, 32'h7FFF_FFFF),
                     mk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000),
                     mk(32'h8000_0000, 32'h8000_0001, 32'hFFFF_FFFF), 3'b111,
                     mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF), 3'b111);
    add("edges", mk(32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0), mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0),
                 mk(32'h8000_0000, 32'h8000_0000, 32'h0), 3'b010,
                 mk(32'h8000_0000, 32'h7FFF_FFFF, 32'h0), 3'b010);

    // Reset state.
    op1 = mk(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset handshake", 96'({ir_w, ir_s, ov_w, ov_s}), 96'd0);
    chk("reset result_wrap", res_w, 96'd0);
    chk("reset result_sat",  res_s, 96'd0);
    chk("reset axis", 96'({ax_w, ax_s, of_w, of_s}), 96'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("reset release in_ready", 96'({ir_w, ir_s}), 96'b11);
    @(negedge clk);

    // Directed table.
    foreach (tbl[i]) run_one(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].rw, tbl[i].ow, tbl[i].rs, tbl[i].os);

    // Backpressure with in_valid held and op1 mutating.
    a = rnd_vec(); b = rnd_vec();
    model(a, b, 1'b0, rw, ow);
    model(a, b, 1'b1, rs, os);
    out_ready = 1'b0;
    send("bp", a, b, 1'b1);
    wait_valid("bp", cnt);
    chk("bp latency", 96'(cnt), 96'd3);
    for (int k = 0; k < 6; k++) begin
      check_out("bp stall", rw, ow, rs, os);
      chk("bp stall handshake", 96'({ov_w, ov_s, ir_w, ir_s}), 96'b1100);
      op1 = rnd_vec();
      @(posedge clk);
      @(negedge clk);
    end
    c2 = rnd_vec();
    op1 = c2;
    op2 = a;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp release idle", 96'({ov_w, ov_s, ir_w, ir_s}), 96'b0011);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op1 = rnd_vec();
    chk("bp second accept", 96'({ir_w, ir_s}), 96'd0);
    wait_valid("bp2", cnt);
    chk("bp2 latency", 96'(cnt), 96'd3);
    model(c2, a, 1'b0, rw, ow);
    model(c2, a, 1'b1, rs, os);
    check_out("bp2", rw, ow, rs, os);
    $display("txn backpressure second vector wrap=%h sat=%h", res_w, res_s);
    @(posedge clk);
    @(negedge clk);

    // Reset while in SUB_Y.
    a = rnd_vec(); b = rnd_vec();
    send("rst", a, b, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst handshake", 96'({ir_w, ir_s, ov_w, ov_s}), 96'd0);
    chk("rst result_wrap", res_w, 96'd0);
    chk("rst result_sat",  res_s, 96'd0);
    chk("rst axis", 96'({ax_w, ax_s}), 96'd0);
    rst_n = 1'b1;
    #1;
    chk("rst release in_ready", 96'({ir_w, ir_s}), 96'b11);
    $display("txn reset mid-operation");
    a = rnd_vec(); b = rnd_vec();
    model(a, b, 1'b0, rw, ow);
    model(a, b, 1'b1, rs, os);
    run_one("after_rst", a, b, rw, ow, rs, os);

    // Back-to-back random vectors, in_valid and out_ready always high.
    out_ready = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      a = rnd_vec(); b = rnd_vec();
      model(a, b, 1'b0, rw, ow);
      model(a, b, 1'b1, rs, os);
      send("b2b", a, b, 1'b1);
      wait_valid("b2b", cnt);
      chk("b2b latency", 96'(cnt), 96'd3);
      if (k > 0) chk("b2b spacing", 96'(cyc - t_prev), 96'd5);
      t_prev = cyc;
      check_out("b2b", rw, ow, rs, os);
      $display("txn b2b %0d op1=%h op2=%h wrap=%h/%b sat=%h/%b", k, a, b, res_w, ax_w, res_s, ax_s);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Extra random single transactions.
    for (int k = 0; k < 8; k++) begin
      a = rnd_vec(); b = rnd_vec();
      if (k == 0) b = a;
      model(a, b, 1'b0, rw, ow);
      model(a, b, 1'b1, rs, os);
      run_one("rand", a, b, rw, ow, rs, os);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
